// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 5-stage RV32 core: load-use stalls, taken-branch flushes
// and data-memory wait/timeout handling. Optional performance counters via PERF_CNT_EN.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam int TW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);

    state_t          state_r;
    state_t          state_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_s;
    logic            mem_err_r;
    logic            uses_rs2_s;
    logic            taken_s;
    logic            lu_s;
    logic            abort_s;
    logic            hold_s;

    // Hazard conditions derived from the staged control bits
    always_comb begin
        uses_rs2_s = (id_opcode == 7'b0110011) || (id_opcode == 7'b0100011) ||
                     (id_opcode == 7'b1100011);
        case (ex_funct3)
            3'b000:  taken_s = ex_branch & ex_zero;
            3'b001:  taken_s = ex_branch & ~ex_zero;
            default: taken_s = 1'b0;
        endcase
        lu_s    = ex_memread && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (uses_rs2_s && (ex_rd == id_rs2)));
        abort_s = (state_r == ABORT);
        hold_s  = mem_access & ~dmem_ready & ~abort_s;
    end

    // Next-state and wait timer
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            RUN: begin
                if (hold_s) begin
                    state_s = MWAIT;
                    timer_s = TIMER_ONE;
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end
            MWAIT: begin
                if (dmem_ready || !mem_access) begin
                    state_s = RUN;
                    timer_s = TIMER_ZERO;
                end else if (timer_r == TIMER_LAST) begin
                    state_s = ABORT;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ABORT: begin
                state_s = RUN;
                timer_s = TIMER_ZERO;
            end
            default: begin
                state_s = RUN;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // State, timer and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= RUN;
            timer_r   <= TIMER_ZERO;
            mem_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            if (abort_s) begin
                mem_err_r <= 1'b1;
            end
        end
    end

    // Pipeline control, priority hold > taken > load-use; everything forced low in reset
    always_comb begin
        dmem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            dmem_req = 1'b0;
        end else begin
            dmem_req     = mem_access & ~abort_s;
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            idex_write   = 1'b1;
            exmem_write  = 1'b1;
            memwb_bubble = abort_s;
            if (hold_s) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
            end else if (taken_s) begin
                pc_src     = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_s) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else begin
                pc_src = 1'b0;
            end
        end
    end

    assign mem_err = mem_err_r;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_r;
    logic [CNT_W-1:0] flush_r;
    logic [CNT_W-1:0] wait_r;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Performance counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r <= {CNT_W{1'b0}};
            flush_r <= {CNT_W{1'b0}};
            wait_r  <= {CNT_W{1'b0}};
        end else begin
            if (lu_s && !taken_s && !hold_s) begin
                stall_r <= stall_r + CNT_ONE;
            end
            if (taken_s && !hold_s) begin
                flush_r <= flush_r + CNT_ONE;
            end
            if (hold_s) begin
                wait_r <= wait_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_r;
    assign flush_cnt = flush_r;
    assign wait_cnt  = wait_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
    assign wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized self-checking bench for hazard_sequencer against a cycle-level reference model.
module tb_hazard_sequencer;
    localparam int MT    = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic [6:0] id_opcode;
    logic ex_memread, ex_branch, ex_zero, mem_access, dmem_ready;
    logic [2:0] ex_funct3;
    logic dmem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, memwb_bubble, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    hazard_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_opcode(id_opcode),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_zero(ex_zero), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_flush(idex_flush),
        .exmem_write(exmem_write), .memwb_bubble(memwb_bubble), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: consecutive not-ready cycles, pending abort, sticky error, counters
    int          m_consec;
    bit          m_abort;
    bit          m_err;
    int unsigned m_stall, m_flush, m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {22'd0, dmem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_write,
                idex_flush, exmem_write, memwb_bubble, mem_err};
    endfunction

    task automatic model_clear();
        m_consec = 0; m_abort = 1'b0; m_err = 1'b0;
        m_stall = 0; m_flush = 0; m_wait = 0;
    endtask

    task automatic check_counters(input string tag);
`ifdef PERF_CNT_EN
        check({tag, "_stall"}, stall_cnt, m_stall);
        check({tag, "_flush"}, flush_cnt, m_flush);
        check({tag, "_wait"},  wait_cnt,  m_wait);
`else
        check({tag, "_cnt_tied"}, stall_cnt | flush_cnt | wait_cnt, 32'd0);
`endif
    endtask

    // one clock cycle: apply inputs, compare outputs with the model, advance the model
    task automatic cycle(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] op, input logic [4:0] rd, input logic mr,
                         input logic br, input logic [2:0] f3, input logic z,
                         input logic ma, input logic rdy);
        bit taken, lu, hold, uses2;
        bit e_req, e_pcw, e_src, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub;
        id_rs1 = rs1; id_rs2 = rs2; id_opcode = op; ex_rd = rd; ex_memread = mr;
        ex_branch = br; ex_funct3 = f3; ex_zero = z; mem_access = ma; dmem_ready = rdy;
        #1;
        uses2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
        taken = br && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z));
        lu    = mr && rd != 5'd0 && (rd == rs1 || (uses2 && rd == rs2));
        hold  = !m_abort && ma && !rdy;
        e_req = ma && !m_abort;
        e_pcw = 1'b1; e_ifw = 1'b1; e_idw = 1'b1; e_exw = 1'b1;
        e_src = 1'b0; e_iff = 1'b0; e_idf = 1'b0; e_bub = m_abort;
        if (hold) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_idw = 1'b0; e_exw = 1'b0; e_bub = 1'b1;
        end else if (taken) begin
            e_src = 1'b1; e_iff = 1'b1; e_idf = 1'b1;
        end else if (lu) begin
            e_pcw = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
        end
        check(tag, dut_outs(), {22'd0, e_req, e_pcw, e_src, e_ifw, e_iff, e_idw, e_idf,
                                e_exw, e_bub, m_err});
        check_counters(tag);
        @(posedge clk);
        if (hold) m_wait++;
        if (taken && !hold) m_flush++;
        if (lu && !taken && !hold) m_stall++;
        if (m_abort) begin
            m_err = 1'b1; m_abort = 1'b0; m_consec = 0;
        end else if (hold) begin
            m_consec++;
            if (m_consec == MT) begin
                m_abort = 1'b1; m_consec = 0;
            end
        end else begin
            m_consec = 0;
        end
        @(negedge clk);
    endtask

    // asynchronous reset pulse asserted between clock edges
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_outs"}, dut_outs(), 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_counters({tag, "_post"});
    endtask

    initial begin
        reset = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_opcode = 7'd0; ex_rd = 5'd0; ex_memread = 1'b0;
        ex_branch = 1'b0; ex_funct3 = 3'd0; ex_zero = 1'b0; mem_access = 1'b1; dmem_ready = 1'b0;
        model_clear();
        #2;
        check("por_outs", dut_outs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_access = 1'b0;

        // load-use on rs1, then the bubble clears ex_memread
        cycle("lu_rs1",  5'd5, 5'd1, 7'b0110011, 5'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cycle("lu_done", 5'd5, 5'd1, 7'b0110011, 5'd5, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        // rs2 hazard only counts for R/S/B opcodes
        cycle("lu_rs2",  5'd2, 5'd7, 7'b0100011, 5'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cycle("no_rs2",  5'd2, 5'd7, 7'b0010011, 5'd7, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cycle("rd_zero", 5'd0, 5'd0, 7'b0110011, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        // taken branches override a simultaneous load-use
        cycle("beq_lu",  5'd5, 5'd1, 7'b0110011, 5'd5, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle("bne_lu",  5'd5, 5'd1, 7'b0110011, 5'd5, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        cycle("beq_nt",  5'd3, 5'd1, 7'b0110011, 5'd9, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        cycle("blt_nt",  5'd3, 5'd1, 7'b0110011, 5'd9, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        // zero-wait access
        cycle("mem_0w",  5'd3, 5'd1, 7'b0000011, 5'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        // three wait cycles with a taken branch frozen underneath, then advance
        for (int i = 0; i < 3; i++)
            cycle("mem_w3", 5'd3, 5'd1, 7'b0110011, 5'd9, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cycle("mem_adv", 5'd3, 5'd1, 7'b0110011, 5'd9, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
        // timeout: never ready -> abort cycle, sticky error
        for (int i = 0; i < MT + 3; i++)
            cycle("timeout", 5'd1, 5'd2, 7'b0110011, 5'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cycle("err_held", 5'd1, 5'd2, 7'b0110011, 5'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        // reset while waiting
        cycle("pre_rst", 5'd1, 5'd2, 7'b0110011, 5'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cycle("pre_rst", 5'd1, 5'd2, 7'b0110011, 5'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        do_reset("rst_mwait");
        cycle("post_rst", 5'd1, 5'd2, 7'b0110011, 5'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // randomized traffic in blocks with varying memory behaviour
        for (int blk = 0; blk < 40; blk++) begin
            int rdy_pct = $urandom_range(10, 90);
            for (int c = 0; c < 50; c++) begin
                logic ma;
                ma = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
                cycle("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011,
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), ma,
                      ($urandom_range(0, 99) < rdy_pct));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
